// File: rtl/adc_burst_sequencer.sv
// Trigger-started multi-channel ADC sample pacer: pre-delay, then frames of per-channel store strobes.
// Optional `ADC_SEQ_OVERRUN_EN adds a sticky flag for trigger edges that arrive while a run is active.
module adc_burst_sequencer #(
    parameter int CNT_W  = 32,
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic             stop,
    input  logic [CNT_W-1:0] delay_set,
    input  logic [CNT_W-1:0] period_set,
    input  logic [CH_W:0]    ch_cnt_set,
    input  logic [CNT_W-1:0] frames_set,
    output logic             sample_en,
    output logic             adc_data_en,
    output logic [CH_W-1:0]  adc_ch,
    output logic [CNT_W-1:0] frame_idx,
    output logic             busy,
    output logic             done,
    output logic             overrun
);
    // state  | meaning
    // IDLE   | no run active, waiting for a trig rising edge
    // DELAY  | counting the captured pre-delay
    // SAMPLE | one store strobe per cycle, channel 0..ch_n-1
    // WAIT   | padding until period_eff cycles after the frame's first strobe
    typedef enum logic [1:0] {IDLE, DELAY, SAMPLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic             trig_q, arm_q, arm_d, done_q, done_d;
    logic [CNT_W-1:0] tmr_q, tmr_d, period_q, period_d;
    logic [CNT_W-1:0] frames_q, frames_d, frame_q, frame_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W:0]    ch_n_q, ch_n_d, ch_n_clamp;
    logic [CNT_W-1:0] ch_n_ext, period_eff;
    logic             start, last_ch, last_frame, back_to_back;

    // arm_q stops a trig held high across reset release from counting as an edge
    assign start        = trig & ~trig_q & arm_q;
    assign last_ch      = ({1'b0, ch_q} == (ch_n_q - (CH_W+1)'(1)));
    assign last_frame   = (frames_q != '0) && (frame_q == (frames_q - CNT_W'(1)));
    assign back_to_back = (period_q == CNT_W'(ch_n_q));

    always_comb begin
        ch_n_clamp = ch_cnt_set;
        if (ch_cnt_set == '0)
            ch_n_clamp = (CH_W+1)'(1);
        else if (ch_cnt_set > (CH_W+1)'(CH_NUM))
            ch_n_clamp = (CH_W+1)'(CH_NUM);
        ch_n_ext   = CNT_W'(ch_n_clamp);
        period_eff = (period_set < ch_n_ext) ? ch_n_ext : period_set;
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        period_d = period_q;
        frames_d = frames_q;
        frame_d  = frame_q;
        ch_d     = ch_q;
        ch_n_d   = ch_n_q;
        done_d   = 1'b0;
        arm_d    = arm_q | ~trig;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    ch_n_d   = ch_n_clamp;
                    period_d = period_eff;
                    frames_d = frames_set;
                    frame_d  = '0;
                    ch_d     = '0;
                    if (delay_set != '0) begin
                        state_d = DELAY;
                        tmr_d   = delay_set - CNT_W'(1);
                    end else begin
                        state_d = SAMPLE;
                    end
                end
            end
            DELAY: begin
                if (tmr_q == '0) state_d = SAMPLE;
                else             tmr_d   = tmr_q - CNT_W'(1);
            end
            SAMPLE: begin
                // timer value for the cycle after the first strobe; reaches 0 one cycle before the next frame
                if (ch_q == '0) tmr_d = period_q - CNT_W'(2);
                else            tmr_d = tmr_q - CNT_W'(1);
                if (last_ch) begin
                    ch_d = '0;
                    if (last_frame) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + CNT_W'(1);
                        state_d = back_to_back ? SAMPLE : WAIT;
                    end
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            WAIT: begin
                if (tmr_q == '0) state_d = SAMPLE;
                else             tmr_d   = tmr_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            trig_q   <= 1'b0;
            arm_q    <= 1'b0;
            done_q   <= 1'b0;
            tmr_q    <= '0;
            period_q <= '0;
            frames_q <= '0;
            frame_q  <= '0;
            ch_q     <= '0;
            ch_n_q   <= '0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig;
            arm_q    <= arm_d;
            done_q   <= done_d;
            tmr_q    <= tmr_d;
            period_q <= period_d;
            frames_q <= frames_d;
            frame_q  <= frame_d;
            ch_q     <= ch_d;
            ch_n_q   <= ch_n_d;
        end
    end

`ifdef ADC_SEQ_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (start) begin
            if (state_q != IDLE) overrun_d = 1'b1;
            else if (!stop)      overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun_q <= 1'b0;
        else          overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign sample_en   = (state_q != IDLE);
    assign busy        = sample_en;
    assign adc_data_en = (state_q == SAMPLE);
    assign adc_ch      = ch_q;
    assign frame_idx   = frame_q;
    assign done        = done_q;
endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Scoreboard bench for adc_burst_sequencer: expected strobes are queued at trigger time
// and matched against adc_data_en as the DUT produces them.
module tb_adc_burst_sequencer;
    localparam int CNT_W  = 32;
    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;
`ifdef ADC_SEQ_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n, trig, stop;
    logic [CNT_W-1:0] delay_set, period_set, frames_set;
    logic [CH_W:0]    ch_cnt_set;
    logic             sample_en, adc_data_en, busy, done, overrun;
    logic [CH_W-1:0]  adc_ch;
    logic [CNT_W-1:0] frame_idx;

    adc_burst_sequencer #(.CNT_W(CNT_W), .CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
        .clk(clk), .reset_n(reset_n), .trig(trig), .stop(stop),
        .delay_set(delay_set), .period_set(period_set), .ch_cnt_set(ch_cnt_set),
        .frames_set(frames_set), .sample_en(sample_en), .adc_data_en(adc_data_en),
        .adc_ch(adc_ch), .frame_idx(frame_idx), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int ch; int frm;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   nvec = 0, nmis = 0;
    int   done_cnt = 0, last_done = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        if (obs !== expv) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (adc_data_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", adc_data_en, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cyc", cyc, e.cyc);
                chk("strobe_ch", adc_ch, e.ch);
                chk("strobe_frame", frame_idx, e.frm);
            end
        end
    end

    // Called at posedge+2; the trig edge is sampled at the next posedge, so the first busy cycle is cyc+1.
    task automatic start_run(input int d, input int p, input int c, input int f, input int nq,
                             output int b, output int dn);
        int chn, pe;
        delay_set = d; period_set = p; ch_cnt_set = c[CH_W:0]; frames_set = f;
        chn = (c == 0) ? 1 : ((c > CH_NUM) ? CH_NUM : c);
        pe  = (p < chn) ? chn : p;
        trig = 1'b1;
        b  = cyc + 1;
        dn = b + d + (f - 1) * pe + chn;
        for (int k = 0; k < nq; k++)
            for (int j = 0; j < chn; j++)
                sb.push_back('{cyc: b + d + k * pe + j, ch: j, frm: k});
        @(posedge clk); #2;
        trig = 1'b0;
        chk("busy_at_start", busy, 1);
        chk("sample_en_at_start", sample_en, 1);
    endtask

    task automatic wait_done(input int expc);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("done_cyc", last_done, expc);
        chk("idle_in_done_cycle", busy, 0);
        chk("sb_drained", sb.size(), 0);
        @(negedge clk); #1;
        chk("done_one_cycle", done, 0);
        @(posedge clk); #2;
    endtask

    int b, dn, d0;

    initial begin
        reset_n = 1'b0; trig = 1'b0; stop = 1'b0;
        delay_set = '0; period_set = '0; ch_cnt_set = '0; frames_set = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample_en", sample_en, 0);
        chk("rst_data_en", adc_data_en, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_idx", frame_idx, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // delay 3, period 10, 2 channels, 3 frames
        start_run(3, 10, 2, 3, 3, b, dn);
        chk("done_at_busy_plus_25", dn - b, 25);
        wait_done(dn);

        // period below channel count -> back-to-back 4-cycle frames
        start_run(0, 2, 4, 3, 3, b, dn);
        wait_done(dn);

        // channel count clamp: 0 -> 1 and 7 -> 4
        start_run(1, 3, 0, 2, 2, b, dn);
        wait_done(dn);
        start_run(2, 6, 7, 2, 2, b, dn);
        wait_done(dn);

        // continuous, stopped in WAIT after the fourth strobe
        start_run(0, 5, 1, 0, 4, b, dn);
        d0 = done_cnt;
        while (cyc < b + 16) begin @(posedge clk); #2; end
        stop = 1'b1;
        @(posedge clk); #2;
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_sample_en", sample_en, 0);
        repeat (15) @(posedge clk);
        #2;
        chk("stop_no_done", done_cnt - d0, 0);
        chk("stop_sb_drained", sb.size(), 0);

        // trigger edge while busy
        start_run(2, 4, 2, 3, 3, b, dn);
        while (cyc < b + 5) begin @(posedge clk); #2; end
        trig = 1'b1;
        @(posedge clk); #2;
        trig = 1'b0;
        wait_done(dn);
        chk("overrun_after_busy_trig", overrun, OVR);
        start_run(0, 1, 1, 1, 1, b, dn);
        chk("overrun_cleared", overrun, 0);
        wait_done(dn);

        // reset mid-SAMPLE with trig held high through release
        start_run(0, 8, 4, 2, 2, b, dn);
        @(posedge clk); #2;
        trig = 1'b1;
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_data_en", adc_data_en, 0);
        chk("rst_mid_ch", adc_ch, 0);
        chk("rst_mid_frame", frame_idx, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("trig_held_no_start", busy, 0);
        chk("rst_no_done", done_cnt - d0, 0);
        trig = 1'b0;
        @(posedge clk); #2;
        start_run(1, 4, 3, 2, 2, b, dn);
        wait_done(dn);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule

// File: doc/adc_burst_sequencer.md
# adc_burst_sequencer

Parametrised multi-channel ADC sample pacer for the AD9226 acquisition path, sitting between the host command decoder and the ADC capture/FIFO write logic. On a trigger edge it waits a programmable pre-delay, then emits bursts ("frames") of per-channel store strobes at a programmable frame period, for a programmable frame count or continuously. It replaces single-channel, level-started pacing with configuration captured at start, abort, a done pulse and frame indexing.

## Interface
- CNT_W, 32: width of delay, period, frame counters.
- CH_NUM, 4: maximum channels per frame.
- CH_W, 2: channel index width; must satisfy 2^CH_W >= CH_NUM.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- trig  in  1  start request; rising edge detected internally.
- stop  in  1  synchronous abort, level, active-high.
- delay_set  in  CNT_W  cycles from start to first strobe.
- period_set  in  CNT_W  frame-start spacing in cycles.
- ch_cnt_set  in  CH_W+1  channels per frame.
- frames_set  in  CNT_W  frames per run; 0 = continuous.
- sample_en  out  1  high while a run is active (ADC clock gate).
- adc_data_en  out  1  one-cycle store strobe per channel sample.
- adc_ch  out  CH_W  channel index qualified by adc_data_en.
- frame_idx  out  CNT_W  current frame number, from 0, qualified by adc_data_en.
- busy  out  1  equals sample_en.
- done  out  1  one-cycle pulse on normal run completion.
- overrun  out  1  sticky trigger-while-busy flag (see Configuration).

## Operation
- Reset: all outputs 0, state IDLE, trig edge register 0.
- Edge: trig_q registered each cycle; start = trig & ~trig_q.
- Capture at start: delay_set, period_set, frames_set; ch_n = ch_cnt_set clamped to range 1..CH_NUM (0 -> 1, >CH_NUM -> CH_NUM); period_eff = max(period_set, ch_n). Input changes during a run are ignored.
- IDLE: on start -> DELAY if delay_set>0, else SAMPLE; busy/sample_en set.
- DELAY: count delay_set cycles, then SAMPLE.
- SAMPLE: adc_data_en=1 for ch_n consecutive cycles, adc_ch 0..ch_n-1, frame_idx constant. After last channel: if frames_set!=0 and frame_idx==frames_set-1 -> IDLE with done; else WAIT (or directly SAMPLE of next frame if period_eff==ch_n).
- WAIT: idle until period_eff cycles since frame's first strobe, then SAMPLE with frame_idx+1.
- Continuous mode: frame_idx wraps 2^CNT_W-1 -> 0; run ends only by stop.
- stop (any non-IDLE state, priority over everything): next cycle IDLE, busy/sample_en/adc_data_en 0, no done. stop in IDLE blocks start in that cycle.
- Start edge while busy: ignored (except overrun flag).

## Timing
- trig rises, sampled at edge E: busy=1 from E+1.
- First strobe at cycle (E+1)+delay_set; delay_set=0 -> strobe in first busy cycle.
- Frame k first strobe = first-frame strobe + k*period_eff.
- done and busy=0 in the cycle after the last strobe; done high exactly one cycle.
- New start edge accepted in the done cycle (state already IDLE).
- Reset mid-run: outputs 0 immediately (asynchronous), no done.

## Configuration
- ADC_SEQ_OVERRUN_EN defined: start edge while busy sets overrun; cleared only by reset or by the next accepted start edge in IDLE.
- Undefined: overrun tied 0, overrun logic removed; busy-time triggers silently ignored.

## Test plan
- delay=3, period=10, ch_cnt=2, frames=3, trig pulse -> strobes at busy+3/4, +13/14, +23/24, adc_ch 0,1, frame_idx 0,1,2; done at busy+25.
- ch_cnt=4, period=2 -> period_eff=4, 4-cycle back-to-back frames, adc_data_en continuously high, adc_ch 0..3 repeating.
- frames=0, period=5, ch_cnt=1 -> strobes every 5 cycles indefinitely; stop mid-WAIT -> busy 0 next cycle, no done, no further strobes.
- ch_cnt=0 and ch_cnt=7 (CH_NUM=4) -> 1 and 4 channels per frame respectively.
- Second trig edge mid-run -> run unaffected; overrun=1 with ADC_SEQ_OVERRUN_EN, 0 without; next start in IDLE clears it.
- reset_n low mid-SAMPLE -> all outputs 0 at once; trig held high through reset release -> no start until low then high again.
